// File: rtl/req_arbiter_rr.sv
// req_arbiter_rr: shares one downstream resource between N requesters.
// A grant goes to exactly one requester at a time. Fixed mode picks the lowest
// active index. Round-robin mode starts its search just after the last winner.
// A grant is held until the owner asserts done, drops its request, or the
// optional hold timeout expires. Every grant is followed by one IDLE cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_i        request vector, bit i = requester i
//   done_i       current owner releases the resource (ignored in IDLE)
//   mode_i       0 = fixed priority, 1 = round robin (sampled at arbitration)
//   gnt_o        one-hot grant, zero when there is no owner
//   gnt_idx_o    binary index of the owner; holds its last value when idle
//   gnt_valid_o  high while a grant is held
//   timeout_o    one-cycle pulse when a grant is revoked by the hold timeout
module req_arbiter_rr #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDXW     = 3,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNTW     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_i,
  input  logic            done_i,
  input  logic            mode_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            gnt_valid_o,
  output logic            timeout_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDXW-1:0] last_idx_q, last_idx_d;
  logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;
  logic            timeout_q, timeout_d;

  logic [IDXW-1:0] win_idx;
  logic            win_found;
  int unsigned     cand;

  logic            rel_done, rel_drop, rel_to;

  // Winner search. Round robin walks last_idx+1 .. last_idx with wrap, so a
  // lone request from last_idx is found last and regranted.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (mode_i) begin
        cand = (32'(last_idx_q) + 32'(i) + 32'd1) % N;
      end else begin
        cand = 32'(i);
      end
      if (!win_found && req_i[IDXW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDXW'(cand);
      end
    end
  end

  always_comb begin
    rel_done = done_i;
    rel_drop = !req_i[gnt_idx_q];
    rel_to   = (MAX_HOLD != 0) && (hold_cnt_q == CNTW'(MAX_HOLD - 1));
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StGrant;
          gnt_idx_d  = win_idx;
          last_idx_d = win_idx;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        if (rel_done || rel_drop || rel_to) begin
          state_d    = StIdle;
          hold_cnt_d = '0;
          // The pulse flags only a revocation the owner did not ask for.
          timeout_d  = rel_to && !rel_done && !rel_drop;
        end else if (MAX_HOLD == 0) begin
          if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (hold_cnt_q < CNTW'(MAX_HOLD - 1)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_idx_q  <= '0;
      last_idx_q <= IDXW'(N - 1);
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs come straight from registers, so an async reset clears them at once.
  always_comb begin
    gnt_valid_o         = (state_q == StGrant);
    gnt_o               = '0;
    gnt_o[gnt_idx_q]    = gnt_valid_o;
    gnt_idx_o           = gnt_idx_q;
    timeout_o           = timeout_q;
  end

endmodule

// File: tb/tb_req_arbiter_rr.sv
module tb_req_arbiter_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       mode;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  req_arbiter_rr #(
    .N       (8),
    .IDXW    (3),
    .MAX_HOLD(16),
    .CNTW    (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .done_i     (done),
    .mode_i     (mode),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .timeout_o  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    mode  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    total++; if (gnt !== 8'h00) begin bad++; $display("FAIL reset_gnt got=%h want=00", gnt); end
    total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", gnt_idx); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", gnt_valid); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
  endtask

  task automatic test_fixed();
    mode = 1'b0;
    req  = 8'b1010_0100;
    tick();
    total++; if (gnt !== 8'h04) begin bad++; $display("FAIL fixed_gnt got=%h want=04", gnt); end
    total++; if (gnt_idx !== 3'd2) begin bad++; $display("FAIL fixed_idx got=%0d want=2", gnt_idx); end
    total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL fixed_valid got=%b want=1", gnt_valid); end
    tick();
    tick();
    total++; if (gnt !== 8'h04) begin bad++; $display("FAIL fixed_hold got=%h want=04", gnt); end
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 8'h00) begin bad++; $display("FAIL fixed_release got=%h want=00", gnt); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL fixed_rel_valid got=%b want=0", gnt_valid); end
    total++; if (gnt_idx !== 3'd2) begin bad++; $display("FAIL fixed_idx_hold got=%0d want=2", gnt_idx); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL fixed_rel_timeout got=%b want=0", timeout); end
    tick();
    total++; if (gnt !== 8'h04) begin bad++; $display("FAIL fixed_regrant got=%h want=04", gnt); end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp = 3'(k % 8);
      tick();
      total++; if (gnt_idx !== exp || gnt !== (8'h01 << exp)) begin
        bad++; $display("FAIL rr_order step=%0d got idx=%0d gnt=%h want idx=%0d", k, gnt_idx, gnt, exp);
      end
      total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL rr_valid step=%0d got=%b want=1", k, gnt_valid); end
      done = 1'b1;
      tick();
      done = 1'b0;
      total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL rr_gap step=%0d got=%b want=0", k, gnt_valid); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    mode = 1'b1;
    req  = 8'b0010_0000;
    tick();
    total++; if (gnt_idx !== 3'd5) begin bad++; $display("FAIL wrap_setup got=%0d want=5", gnt_idx); end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'b0010_0001;
    tick();
    total++; if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
      bad++; $display("FAIL wrap_to_0 got idx=%0d gnt=%h want idx=0 gnt=01", gnt_idx, gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'b0010_0000;
    tick();
    total++; if (gnt_idx !== 3'd5) begin bad++; $display("FAIL wrap_next5 got=%0d want=5", gnt_idx); end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    total++; if (gnt_idx !== 3'd5 || gnt !== 8'h20) begin
      bad++; $display("FAIL wrap_regrant_last got idx=%0d gnt=%h want idx=5 gnt=20", gnt_idx, gnt);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    mode = 1'b0;
    req  = 8'b0000_1000;
    done = 1'b0;
    tick();
    total++; if (gnt !== 8'h08) begin bad++; $display("FAIL to_grant got=%h want=08", gnt); end
    for (int c = 2; c <= 16; c++) begin
      tick();
      total++; if (gnt !== 8'h08 || timeout !== 1'b0) begin
        bad++; $display("FAIL to_held cycle=%0d got gnt=%h to=%b want gnt=08 to=0", c, gnt, timeout);
      end
    end
    tick();
    total++; if (gnt !== 8'h00 || timeout !== 1'b1) begin
      bad++; $display("FAIL to_pulse got gnt=%h to=%b want gnt=00 to=1", gnt, timeout);
    end
    tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_one_cycle got=%b want=0", timeout); end
    total++; if (gnt !== 8'h08) begin bad++; $display("FAIL to_regrant got=%h want=08", gnt); end
    for (int c = 0; c < 15; c++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (gnt !== 8'h00 || timeout !== 1'b0) begin
      bad++; $display("FAIL to_coincide got gnt=%h to=%b want gnt=00 to=0", gnt, timeout);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_drop();
    mode = 1'b0;
    req  = 8'b0001_0000;
    tick();
    total++; if (gnt !== 8'h10) begin bad++; $display("FAIL drop_grant got=%h want=10", gnt); end
    req = 8'b0101_1011;
    tick();
    total++; if (gnt !== 8'h10) begin bad++; $display("FAIL drop_other1 got=%h want=10", gnt); end
    req = 8'b1011_0111;
    tick();
    total++; if (gnt !== 8'h10) begin bad++; $display("FAIL drop_other2 got=%h want=10", gnt); end
    req = 8'b1110_1111;
    tick();
    total++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL drop_release got gnt=%h v=%b to=%b want gnt=00 v=0 to=0", gnt, gnt_valid, timeout);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1;
    req  = 8'b0100_0000;
    tick();
    total++; if (gnt_idx !== 3'd6) begin bad++; $display("FAIL rstmid_setup got=%0d want=6", gnt_idx); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++; $display("FAIL rstmid_async got gnt=%h v=%b to=%b want 00/0/0", gnt, gnt_valid, timeout);
    end
    total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL rstmid_idx got=%0d want=0", gnt_idx); end
    #2 rst_n = 1'b1;
    req = 8'hFF;
    tick();
    total++; if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
      bad++; $display("FAIL rstmid_restart got idx=%0d gnt=%h want idx=0 gnt=01", gnt_idx, gnt);
    end
    req = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    mode  = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
